// File: rtl/difftest_event_serializer_if.sv
`default_nettype none
// ============================================================================
// Module   : difftest_event_serializer_if
// Brief    : 64-bit framed word stream (valid/ready with last marker).
// Revision : 1.0 - initial release
// ============================================================================
interface difftest_event_serializer_if;
    logic [63:0] m_data;
    logic        m_valid;
    logic        m_last;
    logic        m_ready;

    modport master (output m_data, output m_valid, output m_last, input m_ready);
    modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface
`default_nettype wire

// File: rtl/difftest_event_serializer.sv
`default_nettype none
// ============================================================================
// Module   : difftest_event_serializer
// Brief    : Captures one packed difftest event snapshot and emits it as a
//            framed 64-bit stream; snapshots arriving mid-frame are dropped.
// Revision : 1.0 - initial release
// ============================================================================
module difftest_event_serializer #(
    parameter logic [7:0] SYNC   = 8'hA5,
    parameter int         SEQ_W  = 16,
    parameter int         DROP_W = 16
) (
    input  wire                    s_axi_aclk,
    input  wire                    s_axi_aresetn,
    input  wire                    en,
    input  wire  [6:0]             event_valid,
    input  wire  [127:0]           commitevent,
    input  wire  [199:0]           Validevent,
    input  wire  [16:0]            csr_valid,
    input  wire  [1087:0]          csr_data,
    difftest_event_serializer_if.master m,
    output logic                   busy,
    output logic [SEQ_W-1:0]       seq,
    output logic [DROP_W-1:0]      drop_cnt,
    output logic                   overflow
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HDR    = 3'd1,
        S_COMMIT = 3'd2,
        S_VALID  = 3'd3,
        S_CSR    = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [6:0]      r_ev;
    logic [127:0]    r_commit;
    logic [199:0]    r_valid_pl;
    logic [16:0]     r_csr_vec;
    logic [16:0]     r_csr_mask;
    logic [1087:0]   r_csr_data;
    logic [7:0]      r_len;
    logic [1:0]      r_beat;
    logic [SEQ_W-1:0]  r_seq;
    logic [DROP_W-1:0] r_drop;
    logic            r_ovf;

    logic            w_req;
    logic            w_capture;
    logic            w_drop;
    logic            w_xfer;
    logic [4:0]      w_pop;
    logic [7:0]      w_len;
    logic [4:0]      w_csr_idx;
    logic [16:0]     w_csr_rest;
    logic            w_has_valid;
    logic [255:0]    w_valid_ext;
    logic [1:0]      w_beat_nxt;
    logic [16:0]     w_mask_nxt;

    assign w_req       = (|event_valid[5:0]) | (|csr_valid);
    assign w_capture   = (r_state == S_IDLE) && en && w_req;
    assign w_drop      = (r_state != S_IDLE) && w_req;
    assign w_xfer      = m.m_valid && m.m_ready;
    assign w_has_valid = |r_ev[5:1];
    assign w_valid_ext = {56'b0, r_valid_pl};
    assign w_csr_rest  = r_csr_mask & (r_csr_mask - 17'd1);

    assign busy     = (r_state != S_IDLE);
    assign seq      = r_seq;
    assign drop_cnt = r_drop;
    assign overflow = r_ovf;

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < 17; i++) begin
            w_pop = w_pop + 5'(csr_valid[i]);
        end
        w_len = 8'(w_pop) + (event_valid[0] ? 8'd2 : 8'd0) + ((|event_valid[5:1]) ? 8'd4 : 8'd0);
    end

    // Lowest set bit of the remaining mask selects the next CSR word.
    always_comb begin
        w_csr_idx = '0;
        for (int i = 16; i >= 0; i--) begin
            if (r_csr_mask[i]) w_csr_idx = 5'(i);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_beat_nxt  = r_beat;
        w_mask_nxt  = r_csr_mask;
        m.m_valid   = (r_state != S_IDLE);
        m.m_data    = '0;
        m.m_last    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_capture) w_state_nxt = S_HDR;
            end
            S_HDR: begin
                m.m_data = {SYNC, 1'b0, r_ev, 7'b0, r_csr_vec, 16'(r_seq), r_len};
                m.m_last = (r_len == 8'd0);
                if (w_xfer) begin
                    w_beat_nxt = '0;
                    if (r_ev[0])                w_state_nxt = S_COMMIT;
                    else if (w_has_valid)       w_state_nxt = S_VALID;
                    else if (r_csr_mask != '0)  w_state_nxt = S_CSR;
                    else                        w_state_nxt = S_IDLE;
                end
            end
            S_COMMIT: begin
                m.m_data = r_beat[0] ? r_commit[127:64] : r_commit[63:0];
                m.m_last = r_beat[0] && !w_has_valid && (r_csr_mask == '0);
                if (w_xfer) begin
                    if (r_beat[0]) begin
                        w_beat_nxt = '0;
                        if (w_has_valid)            w_state_nxt = S_VALID;
                        else if (r_csr_mask != '0)  w_state_nxt = S_CSR;
                        else                        w_state_nxt = S_IDLE;
                    end else begin
                        w_beat_nxt = r_beat + 2'd1;
                    end
                end
            end
            S_VALID: begin
                m.m_data = w_valid_ext[r_beat*64 +: 64];
                m.m_last = (r_beat == 2'd3) && (r_csr_mask == '0);
                if (w_xfer) begin
                    w_beat_nxt = r_beat + 2'd1;
                    if (r_beat == 2'd3) begin
                        w_state_nxt = (r_csr_mask != '0) ? S_CSR : S_IDLE;
                    end
                end
            end
            S_CSR: begin
                m.m_data = r_csr_data[w_csr_idx*64 +: 64];
                m.m_last = (w_csr_rest == '0);
                if (w_xfer) begin
                    w_mask_nxt = w_csr_rest;
                    if (w_csr_rest == '0) w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_state    <= S_IDLE;
            r_ev       <= '0;
            r_commit   <= '0;
            r_valid_pl <= '0;
            r_csr_vec  <= '0;
            r_csr_mask <= '0;
            r_csr_data <= '0;
            r_len      <= '0;
            r_beat     <= '0;
            r_seq      <= '0;
            r_drop     <= '0;
            r_ovf      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_beat  <= w_beat_nxt;
            if (w_capture) begin
                r_ev       <= event_valid;
                r_commit   <= commitevent;
                r_valid_pl <= Validevent;
                r_csr_vec  <= csr_valid;
                r_csr_mask <= csr_valid;
                r_csr_data <= csr_data;
                r_len      <= w_len;
                r_beat     <= '0;
            end else begin
                r_csr_mask <= w_mask_nxt;
            end
            if ((r_state == S_HDR) && w_xfer) r_seq <= r_seq + SEQ_W'(1);
            if (w_drop) begin
                r_ovf <= 1'b1;
                if (r_drop != {DROP_W{1'b1}}) r_drop <= r_drop + DROP_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_difftest_event_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_difftest_event_serializer
// Brief    : Directed self-checking bench for the event serializer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_difftest_event_serializer;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic [6:0]    ev = '0;
    logic [127:0]  commitevent = '0;
    logic [199:0]  validevent = '0;
    logic [16:0]   csr_valid = '0;
    logic [1087:0] csr_data = '0;
    logic          busy;
    logic [15:0]   seq;
    logic [15:0]   drop_cnt;
    logic          overflow;
    int            n_tests = 0;
    int            n_fail = 0;
    logic [63:0]   exp[$];

    difftest_event_serializer_if bus();

    difftest_event_serializer dut (
        .s_axi_aclk    (clk),
        .s_axi_aresetn (rst_n),
        .en            (en),
        .event_valid   (ev),
        .commitevent   (commitevent),
        .Validevent    (validevent),
        .csr_valid     (csr_valid),
        .csr_data      (csr_data),
        .m             (bus.master),
        .busy          (busy),
        .seq           (seq),
        .drop_cnt      (drop_cnt),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] hdr(input logic [6:0] e, input logic [16:0] c,
                                        input logic [15:0] s, input logic [7:0] l);
        return {8'hA5, 1'b0, e, 7'b0, c, s, l};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        bus.m_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (bus.m_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid: got m_valid=%b busy=%b, want 0 0", bus.m_valid, busy);
        end
        n_tests++;
        if (seq !== 16'h0 || drop_cnt !== 16'h0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_cnt: got seq=%h drop=%h ovf=%b, want 0 0 0", seq, drop_cnt, overflow);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_commit_only();
        exp.delete();
        exp.push_back(hdr(7'h01, 17'h0, 16'h0000, 8'd2));
        exp.push_back(64'h8899AABBCCDDEEFF);
        exp.push_back(64'h0011223344556677);
        en = 1'b1;
        bus.m_ready = 1'b1;
        ev = 7'h01;
        commitevent = 128'h00112233445566778899AABBCCDDEEFF;
        csr_valid = '0;
        @(negedge clk);
        ev = '0;
        for (int k = 0; k < exp.size(); k++) begin
            n_tests++;
            if (bus.m_valid !== 1'b1 || bus.m_data !== exp[k] || bus.m_last !== (k == exp.size() - 1)) begin
                n_fail++;
                $display("FAIL commit_word%0d: got v=%b d=%h l=%b, want v=1 d=%h l=%b",
                         k, bus.m_valid, bus.m_data, bus.m_last, exp[k], (k == exp.size() - 1));
            end
            @(negedge clk);
        end
        n_tests++;
        if (bus.m_valid !== 1'b0 || busy !== 1'b0 || seq !== 16'd1) begin
            n_fail++;
            $display("FAIL commit_end: got v=%b busy=%b seq=%0d, want 0 0 1", bus.m_valid, busy, seq);
        end
    endtask

    task automatic test_multi_section();
        commitevent = {64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
        validevent  = {8'hEE, 64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        for (int i = 0; i < 17; i++) csr_data[64*i +: 64] = 64'hBAD0_0000_0000_0000 + 64'(i);
        csr_data[63:0]      = 64'h1;
        csr_data[1087:1024] = 64'hDEAD;
        exp.delete();
        exp.push_back(hdr(7'h09, 17'h10001, 16'd1, 8'd8));
        exp.push_back(64'hAAAA_AAAA_AAAA_AAAA);
        exp.push_back(64'hBBBB_BBBB_BBBB_BBBB);
        exp.push_back(64'h1111_1111_1111_1111);
        exp.push_back(64'h2222_2222_2222_2222);
        exp.push_back(64'h3333_3333_3333_3333);
        exp.push_back(64'h0000_0000_0000_00EE);
        exp.push_back(64'h1);
        exp.push_back(64'hDEAD);
        ev = 7'h09;
        csr_valid = 17'h10001;
        @(negedge clk);
        ev = '0;
        csr_valid = '0;
        for (int k = 0; k < exp.size(); k++) begin
            n_tests++;
            if (bus.m_valid !== 1'b1 || bus.m_data !== exp[k] || bus.m_last !== (k == exp.size() - 1)) begin
                n_fail++;
                $display("FAIL multi_word%0d: got v=%b d=%h l=%b, want v=1 d=%h l=%b",
                         k, bus.m_valid, bus.m_data, bus.m_last, exp[k], (k == exp.size() - 1));
            end
            @(negedge clk);
        end
        n_tests++;
        if (bus.m_valid !== 1'b0 || seq !== 16'd2) begin
            n_fail++;
            $display("FAIL multi_end: got v=%b seq=%0d, want 0 2", bus.m_valid, seq);
        end
    endtask

    task automatic test_stall_all_csr();
        int k;
        int cyc;
        for (int i = 0; i < 17; i++) csr_data[64*i +: 64] = 64'h5A00_0000_0000_0000 + 64'(i);
        exp.delete();
        exp.push_back(hdr(7'h00, 17'h1FFFF, 16'd2, 8'd17));
        for (int i = 0; i < 17; i++) exp.push_back(64'h5A00_0000_0000_0000 + 64'(i));
        bus.m_ready = 1'b1;
        csr_valid = 17'h1FFFF;
        @(negedge clk);
        csr_valid = '0;
        k = 0;
        cyc = 0;
        while (k < 18 && cyc < 100) begin
            n_tests++;
            if (bus.m_valid !== 1'b1 || bus.m_data !== exp[k] || bus.m_last !== (k == 17)) begin
                n_fail++;
                $display("FAIL stall_word%0d: got v=%b d=%h l=%b, want v=1 d=%h l=%b",
                         k, bus.m_valid, bus.m_data, bus.m_last, exp[k], (k == 17));
            end
            bus.m_ready = ~bus.m_ready;
            if (bus.m_ready) k++;
            cyc++;
            @(negedge clk);
        end
        n_tests++;
        if (k != 18 || bus.m_valid !== 1'b0 || seq !== 16'd3) begin
            n_fail++;
            $display("FAIL stall_end: got words=%0d v=%b seq=%0d, want 18 0 3", k, bus.m_valid, seq);
        end
        bus.m_ready = 1'b1;
    endtask

    task automatic test_drop();
        validevent = {8'h77, 64'hCAFE_0000_0000_0003, 64'hCAFE_0000_0000_0002, 64'hCAFE_0000_0000_0001};
        exp.delete();
        exp.push_back(hdr(7'h02, 17'h0, 16'd3, 8'd4));
        exp.push_back(64'hCAFE_0000_0000_0001);
        exp.push_back(64'hCAFE_0000_0000_0002);
        exp.push_back(64'hCAFE_0000_0000_0003);
        exp.push_back(64'h77);
        ev = 7'h02;
        @(negedge clk);
        ev = '0;
        for (int c = 1; c <= 7; c++) begin
            n_tests++;
            if (c <= 5) begin
                if (bus.m_valid !== 1'b1 || bus.m_data !== exp[c-1] || bus.m_last !== (c == 5)) begin
                    n_fail++;
                    $display("FAIL drop_word%0d: got v=%b d=%h l=%b, want v=1 d=%h l=%b",
                             c - 1, bus.m_valid, bus.m_data, bus.m_last, exp[c-1], (c == 5));
                end
            end else if (bus.m_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL drop_no_second_frame: got m_valid=%b, want 0", bus.m_valid);
            end
            ev = (c == 3) ? 7'h20 : 7'h00;
            @(negedge clk);
        end
        n_tests++;
        if (drop_cnt !== 16'd1 || overflow !== 1'b1 || seq !== 16'd4) begin
            n_fail++;
            $display("FAIL drop_cnt: got drop=%0d ovf=%b seq=%0d, want 1 1 4", drop_cnt, overflow, seq);
        end
        en = 1'b0;
        ev = 7'h01;
        repeat (3) @(negedge clk);
        n_tests++;
        if (bus.m_valid !== 1'b0 || busy !== 1'b0 || drop_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL en_low_ignore: got v=%b busy=%b drop=%0d, want 0 0 1", bus.m_valid, busy, drop_cnt);
        end
        ev = '0;
        en = 1'b1;
    endtask

    task automatic test_reset_mid_frame();
        ev = 7'h02;
        @(negedge clk);
        ev = '0;
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b1 || bus.m_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_pre: got busy=%b v=%b, want 1 1", busy, bus.m_valid);
        end
        #1 rst_n = 1'b0;
        #1;
        n_tests++;
        if (bus.m_valid !== 1'b0 || busy !== 1'b0 || seq !== 16'd0 || drop_cnt !== 16'd0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_async: got v=%b busy=%b seq=%0d drop=%0d ovf=%b, want 0 0 0 0 0",
                     bus.m_valid, busy, seq, drop_cnt, overflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        exp.delete();
        exp.push_back(hdr(7'h01, 17'h0, 16'd0, 8'd2));
        exp.push_back(64'h0123_4567_89AB_CDEF);
        exp.push_back(64'hFEDC_BA98_7654_3210);
        commitevent = {64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF};
        ev = 7'h01;
        @(negedge clk);
        ev = '0;
        for (int k = 0; k < exp.size(); k++) begin
            n_tests++;
            if (bus.m_valid !== 1'b1 || bus.m_data !== exp[k] || bus.m_last !== (k == exp.size() - 1)) begin
                n_fail++;
                $display("FAIL rst_clean_word%0d: got v=%b d=%h l=%b, want v=1 d=%h l=%b",
                         k, bus.m_valid, bus.m_data, bus.m_last, exp[k], (k == exp.size() - 1));
            end
            @(negedge clk);
        end
        n_tests++;
        if (bus.m_valid !== 1'b0 || seq !== 16'd1) begin
            n_fail++;
            $display("FAIL rst_clean_end: got v=%b seq=%0d, want 0 1", bus.m_valid, seq);
        end
    endtask

    task automatic test_back_to_back();
        csr_data[128 +: 64] = 64'h2222_0000_ABCD_0002;
        csr_valid = 17'h00004;
        @(negedge clk);
        n_tests++;
        if (bus.m_valid !== 1'b1 || bus.m_data !== hdr(7'h00, 17'h4, 16'd1, 8'd1) || bus.m_last !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_hdr_a: got v=%b d=%h l=%b, want v=1 d=%h l=0",
                     bus.m_valid, bus.m_data, bus.m_last, hdr(7'h00, 17'h4, 16'd1, 8'd1));
        end
        @(negedge clk);
        n_tests++;
        if (bus.m_valid !== 1'b1 || bus.m_data !== 64'h2222_0000_ABCD_0002 || bus.m_last !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_csr_a: got v=%b d=%h l=%b, want v=1 d=2222_0000_abcd_0002 l=1",
                     bus.m_valid, bus.m_data, bus.m_last);
        end
        @(negedge clk);
        n_tests++;
        if (bus.m_valid !== 1'b0 || busy !== 1'b0 || drop_cnt !== 16'd2) begin
            n_fail++;
            $display("FAIL b2b_gap: got v=%b busy=%b drop=%0d, want 0 0 2", bus.m_valid, busy, drop_cnt);
        end
        @(negedge clk);
        n_tests++;
        if (bus.m_valid !== 1'b1 || bus.m_data !== hdr(7'h00, 17'h4, 16'd2, 8'd1)) begin
            n_fail++;
            $display("FAIL b2b_hdr_b: got v=%b d=%h, want v=1 d=%h",
                     bus.m_valid, bus.m_data, hdr(7'h00, 17'h4, 16'd2, 8'd1));
        end
        csr_valid = '0;
        @(negedge clk);
        n_tests++;
        if (bus.m_valid !== 1'b1 || bus.m_data !== 64'h2222_0000_ABCD_0002 || bus.m_last !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_csr_b: got v=%b d=%h l=%b, want v=1 d=2222_0000_abcd_0002 l=1",
                     bus.m_valid, bus.m_data, bus.m_last);
        end
        @(negedge clk);
        n_tests++;
        if (bus.m_valid !== 1'b0 || drop_cnt !== 16'd2 || seq !== 16'd3) begin
            n_fail++;
            $display("FAIL b2b_end: got v=%b drop=%0d seq=%0d, want 0 2 3", bus.m_valid, drop_cnt, seq);
        end
    endtask

    task automatic test_drop_saturation();
        int cyc;
        bus.m_ready = 1'b0;
        commitevent = 128'h1;
        ev = 7'h01;
        @(negedge clk);
        ev = 7'h20;
        repeat (1000) @(negedge clk);
        n_tests++;
        if (drop_cnt !== 16'd1002 || overflow !== 1'b1 || bus.m_data !== hdr(7'h01, 17'h0, 16'd3, 8'd2)) begin
            n_fail++;
            $display("FAIL sat_mid: got drop=%0d ovf=%b d=%h, want 1002 1 %h",
                     drop_cnt, overflow, bus.m_data, hdr(7'h01, 17'h0, 16'd3, 8'd2));
        end
        repeat (65000) @(negedge clk);
        n_tests++;
        if (drop_cnt !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL sat_full: got drop=%h, want ffff", drop_cnt);
        end
        ev = '0;
        bus.m_ready = 1'b1;
        cyc = 0;
        while (bus.m_valid === 1'b1 && cyc < 10) begin
            cyc++;
            @(negedge clk);
        end
        n_tests++;
        if (cyc != 3 || busy !== 1'b0 || drop_cnt !== 16'hFFFF || seq !== 16'd4) begin
            n_fail++;
            $display("FAIL sat_drain: got words=%0d busy=%b drop=%h seq=%0d, want 3 0 ffff 4",
                     cyc, busy, drop_cnt, seq);
        end
    endtask

    initial begin
        test_reset();
        test_commit_only();
        test_multi_section();
        test_stall_all_csr();
        test_drop();
        test_reset_mid_frame();
        test_back_to_back();
        test_drop_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
